// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and the GF(2^8) helpers behind the S-box lanes.
package aes_pkg;
  localparam int AES_BLOCK_W   = 128;
  localparam int AES_NUM_BYTES = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction
endpackage

// File: rtl/aes_sub_bytes_iter_if.sv
// Handshake bundle for one aes_sub_bytes_iter instance (producer and consumer sides).
interface aes_sub_bytes_iter_if;
  import aes_pkg::*;
  logic [AES_BLOCK_W-1:0] data_in;
  logic                   inv;
  logic                   valid;
  logic                   ready;
  logic [AES_BLOCK_W-1:0] data_out;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;

  modport master (output data_in, inv, valid, out_ready,
                  input  ready, data_out, out_valid, busy);
  modport slave  (input  data_in, inv, valid, out_ready,
                  output ready, data_out, out_valid, busy);
endinterface

// File: rtl/aes_sbox_lane.sv
// One combinational byte lane holding both the forward and inverse S-box.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] data_in,
  input  logic       sel_inv,
  output logic [7:0] data_out
);
  assign data_out = sel_inv ? sbox_inv(data_in) : sbox_fwd(data_in);
endmodule

// File: rtl/aes_sub_bytes_iter.sv
// Iterative SubBytes: LANES S-boxes sweep the 16-byte state over 16/LANES cycles.
module aes_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   i_aes_sub_bytes_iter_clk,
  input  logic                   i_aes_sub_bytes_iter_rst_n,
  input  logic [AES_BLOCK_W-1:0] i_aes_sub_bytes_iter_data_in,
  input  logic                   i_aes_sub_bytes_iter_inv,
  input  logic                   i_aes_sub_bytes_iter_valid,
  output logic                   o_aes_sub_bytes_iter_ready,
  output logic [AES_BLOCK_W-1:0] o_aes_sub_bytes_iter_data_out,
  output logic                   o_aes_sub_bytes_iter_valid,
  input  logic                   i_aes_sub_bytes_iter_out_ready,
  output logic                   o_aes_sub_bytes_iter_busy
);
  localparam int N  = AES_NUM_BYTES / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]                     state;
  logic [CW-1:0]                  cnt;
  logic                           mode;
  logic [AES_NUM_BYTES-1:0][7:0]  wk;
  logic [LANES-1:0][7:0]          lane_in, lane_out;
  logic [LANES-1:0][3:0]          lane_idx;
  logic                           accept;

  // wk[15] is byte 0 (MSB), so byte k of the group lives at wk[15-k]
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = 4'(AES_NUM_BYTES - 1 - (int'(cnt) * LANES + l));
    assign lane_in[l]  = wk[lane_idx[l]];
    aes_sbox_lane u_lane (
      .data_in  (lane_in[l]),
      .sel_inv  (mode),
      .data_out (lane_out[l])
    );
  end

  assign o_aes_sub_bytes_iter_ready = (state == S_IDLE) ||
                                      (state == S_DONE && i_aes_sub_bytes_iter_out_ready);
  assign accept = i_aes_sub_bytes_iter_valid && o_aes_sub_bytes_iter_ready;

  always_ff @(posedge i_aes_sub_bytes_iter_clk or negedge i_aes_sub_bytes_iter_rst_n) begin
    if (!i_aes_sub_bytes_iter_rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      mode  <= 1'b0;
      wk    <= '0;
    end else if (accept) begin
      state <= S_BUSY;
      cnt   <= '0;
      mode  <= i_aes_sub_bytes_iter_inv;
      wk    <= i_aes_sub_bytes_iter_data_in;
    end else begin
      case (state)
        S_BUSY: begin
          for (int l = 0; l < LANES; l++) wk[lane_idx[l]] <= lane_out[l];
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: if (i_aes_sub_bytes_iter_out_ready) state <= S_IDLE;
        default: ;
      endcase
    end
  end

  assign o_aes_sub_bytes_iter_data_out = wk;
  assign o_aes_sub_bytes_iter_valid    = (state == S_DONE);
  assign o_aes_sub_bytes_iter_busy     = (state == S_BUSY);
endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// Bench for aes_sub_bytes_iter: scoreboarded main instance at LANES=4, plus LANES=1/16 latency copies.
module tb_aes_sub_bytes_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] PT   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] CT   = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] P2   = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] C2   = 128'h1628c14beaaceec4f533fc1bc3938263;
  localparam logic [127:0] Z63  = {16{8'h63}};

  aes_sub_bytes_iter_if m ();
  aes_sub_bytes_iter_if b ();
  aes_sub_bytes_iter_if c ();

  aes_sub_bytes_iter #(.LANES(4)) u_dut (
    .i_aes_sub_bytes_iter_clk(clk), .i_aes_sub_bytes_iter_rst_n(rst_n),
    .i_aes_sub_bytes_iter_data_in(m.data_in), .i_aes_sub_bytes_iter_inv(m.inv),
    .i_aes_sub_bytes_iter_valid(m.valid), .o_aes_sub_bytes_iter_ready(m.ready),
    .o_aes_sub_bytes_iter_data_out(m.data_out), .o_aes_sub_bytes_iter_valid(m.out_valid),
    .i_aes_sub_bytes_iter_out_ready(m.out_ready), .o_aes_sub_bytes_iter_busy(m.busy));

  aes_sub_bytes_iter #(.LANES(1)) u_dut1 (
    .i_aes_sub_bytes_iter_clk(clk), .i_aes_sub_bytes_iter_rst_n(rst_n),
    .i_aes_sub_bytes_iter_data_in(b.data_in), .i_aes_sub_bytes_iter_inv(b.inv),
    .i_aes_sub_bytes_iter_valid(b.valid), .o_aes_sub_bytes_iter_ready(b.ready),
    .o_aes_sub_bytes_iter_data_out(b.data_out), .o_aes_sub_bytes_iter_valid(b.out_valid),
    .i_aes_sub_bytes_iter_out_ready(b.out_ready), .o_aes_sub_bytes_iter_busy(b.busy));

  aes_sub_bytes_iter #(.LANES(16)) u_dut16 (
    .i_aes_sub_bytes_iter_clk(clk), .i_aes_sub_bytes_iter_rst_n(rst_n),
    .i_aes_sub_bytes_iter_data_in(c.data_in), .i_aes_sub_bytes_iter_inv(c.inv),
    .i_aes_sub_bytes_iter_valid(c.valid), .o_aes_sub_bytes_iter_ready(c.ready),
    .o_aes_sub_bytes_iter_data_out(c.data_out), .o_aes_sub_bytes_iter_valid(c.out_valid),
    .i_aes_sub_bytes_iter_out_ready(c.out_ready), .o_aes_sub_bytes_iter_busy(c.busy));

  int tests = 0;
  int fails = 0;
  int hs_count = 0;
  logic [127:0] exp_q[$];

  // Output handshakes of the main instance are checked against the scoreboard
  always @(negedge clk) begin
    if (rst_n && m.out_valid && m.out_ready) begin
      hs_count++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_unexpected: got %h, required no output", m.data_out);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (m.data_out !== e) begin
          fails++;
          $display("FAIL scoreboard_data: got %h, required %h", m.data_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!m.out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic accept_block(input logic [127:0] d, input logic iv, input logic [127:0] e);
    int n;
    m.data_in = d;
    m.inv     = iv;
    m.valid   = 1'b1;
    exp_q.push_back(e);
    n = 0;
    while (!m.ready && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (!m.ready) begin
      fails++;
      $display("FAIL accept_timeout: ready=%b, required 1", m.ready);
      void'(exp_q.pop_back());
    end
    tick();
    m.valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++;
    if (m.ready !== 1'b1 || m.out_valid !== 1'b0 || m.busy !== 1'b0 || m.data_out !== '0) begin
      fails++;
      $display("FAIL reset_outputs: rdy=%b ov=%b busy=%b dout=%h, required 1 0 0 0",
               m.ready, m.out_valid, m.busy, m.data_out);
    end
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_forward();
    int cyc;
    m.out_ready = 1'b0;
    accept_block(PT, 1'b0, CT);
    tests++;
    if (m.busy !== 1'b1) begin
      fails++;
      $display("FAIL fwd_busy: busy=%b, required 1", m.busy);
    end
    wait_valid(cyc);
    tests++;
    if (cyc !== 4) begin
      fails++;
      $display("FAIL fwd_latency: %0d cycles, required 4", cyc);
    end
    tests++;
    if (m.data_out !== CT) begin
      fails++;
      $display("FAIL fwd_data: got %h, required %h", m.data_out, CT);
    end
    m.out_ready = 1'b1;
    tick();
    m.out_ready = 1'b0;
    tests++;
    if (m.out_valid !== 1'b0 || m.ready !== 1'b1) begin
      fails++;
      $display("FAIL fwd_to_idle: ov=%b rdy=%b, required 0 1", m.out_valid, m.ready);
    end
  endtask

  task automatic test_inverse();
    int cyc;
    m.out_ready = 1'b0;
    accept_block(CT, 1'b1, PT);
    wait_valid(cyc);
    tests++;
    if (cyc !== 4 || m.data_out !== PT) begin
      fails++;
      $display("FAIL inv_result: %0d cycles data %h, required 4 cycles %h", cyc, m.data_out, PT);
    end
    m.out_ready = 1'b1;
    tick();
    m.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    int hs0;
    hs0 = hs_count;
    m.out_ready = 1'b1;
    m.data_in = P2;
    m.inv     = 1'b0;
    m.valid   = 1'b1;
    exp_q.push_back(C2);
    tick();
    // junk on the inputs while busy must not disturb the block in flight
    m.data_in = {$urandom, $urandom, $urandom, $urandom};
    m.inv     = 1'b1;
    wait_valid(cyc);
    tests++;
    if (cyc !== 4 || m.ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: %0d cycles rdy=%b, required 4 cycles rdy=1", cyc, m.ready);
    end
    m.data_in = PT;
    m.inv     = 1'b0;
    exp_q.push_back(CT);
    tick();
    m.valid = 1'b0;
    tests++;
    if (m.out_valid !== 1'b0 || m.busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_chain: ov=%b busy=%b, required 0 1", m.out_valid, m.busy);
    end
    wait_valid(cyc);
    tests++;
    if (cyc !== 4) begin
      fails++;
      $display("FAIL b2b_second_latency: %0d cycles, required 4", cyc);
    end
    tick();
    m.out_ready = 1'b0;
    tests++;
    if (hs_count - hs0 !== 2) begin
      fails++;
      $display("FAIL b2b_handshakes: %0d, required 2", hs_count - hs0);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad;
    m.out_ready = 1'b0;
    accept_block(PT, 1'b0, CT);
    wait_valid(cyc);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m.out_valid !== 1'b1 || m.data_out !== CT || m.ready !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
    end
    m.out_ready = 1'b1;
    tick();
    m.out_ready = 1'b0;
    tests++;
    if (m.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: ov=%b, required 0", m.out_valid);
    end
  endtask

  task automatic test_reset_mid_busy();
    int cyc;
    m.out_ready = 1'b1;
    accept_block(PT, 1'b0, CT);
    tick();
    #1;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    tests++;
    if (m.ready !== 1'b1 || m.out_valid !== 1'b0 || m.busy !== 1'b0 || m.data_out !== '0) begin
      fails++;
      $display("FAIL rst_busy_outputs: rdy=%b ov=%b busy=%b dout=%h, required 1 0 0 0",
               m.ready, m.out_valid, m.busy, m.data_out);
    end
    m.data_in = '0;
    m.inv     = 1'b0;
    m.valid   = 1'b1;
    exp_q.push_back(Z63);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m.valid = 1'b0;
    tests++;
    if (m.busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_first_accept: busy=%b, required 1", m.busy);
    end
    wait_valid(cyc);
    tests++;
    if (cyc !== 4 || m.data_out !== Z63) begin
      fails++;
      $display("FAIL rst_zero_block: %0d cycles data %h, required 4 cycles %h", cyc, m.data_out, Z63);
    end
    tick();
    m.out_ready = 1'b0;
  endtask

  task automatic test_lanes();
    int cyc;
    b.data_in = PT; b.inv = 1'b0; b.valid = 1'b1;
    tick();
    b.valid = 1'b0;
    cyc = 0;
    while (!b.out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    tests++;
    if (cyc !== 16 || b.data_out !== CT) begin
      fails++;
      $display("FAIL lanes1: %0d cycles data %h, required 16 cycles %h", cyc, b.data_out, CT);
    end
    c.data_in = PT; c.inv = 1'b0; c.valid = 1'b1;
    tick();
    c.valid = 1'b0;
    cyc = 0;
    while (!c.out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    tests++;
    if (cyc !== 1 || c.data_out !== CT) begin
      fails++;
      $display("FAIL lanes16: %0d cycles data %h, required 1 cycle %h", cyc, c.data_out, CT);
    end
    tick();
    tick();
  endtask

  initial begin
    m.data_in = '0; m.inv = 1'b0; m.valid = 1'b0; m.out_ready = 1'b0;
    b.data_in = '0; b.inv = 1'b0; b.valid = 1'b0; b.out_ready = 1'b1;
    c.data_in = '0; c.inv = 1'b0; c.valid = 1'b0; c.out_ready = 1'b1;
    test_reset();
    test_forward();
    test_inverse();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_busy();
    test_lanes();
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
